// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the ccff bitstream loader.
// - state_t     : loader FSM states
// - CRC16_POLY  : CRC-16/CCITT polynomial
// - CRC16_INIT  : CRC register seed
// - crc16_step  : one-bit, MSB-first CRC-16/CCITT update
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word buffer for the ccff loader: holds one WORD_W word and presents it
// one bit at a time, LSB first.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clear        : empty the buffer (new load or end of load)
//   i_enable       : loader is in LOAD and still needs bits
//   i_data/i_valid : upstream word stream, o_ready its handshake
//   o_bit          : current bit, meaningful when o_bit_valid=1
//   o_consume      : the current bit is taken at the edge ending this cycle
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_enable,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_bit,
    output logic              o_bit_valid,
    output logic              o_consume
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    logic [WORD_W-1:0] r_buf;
    logic [IDX_W-1:0]  r_idx;
    logic              r_full;
    logic              w_last;

    assign w_last      = (r_idx == LAST_IDX);
    assign o_bit       = r_buf[r_idx];
    assign o_bit_valid = r_full;
    // Whenever enabled, a buffered bit is always taken, so the last bit of a
    // word frees the buffer in the same cycle and the next word can follow.
    assign o_consume   = i_enable & r_full;
    assign o_ready     = i_enable & (~r_full | w_last);

    // Buffer fill / bit index advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf  <= '0;
            r_idx  <= '0;
            r_full <= 1'b0;
        end else if (i_clear) begin
            r_buf  <= '0;
            r_idx  <= '0;
            r_full <= 1'b0;
        end else if (i_valid && o_ready) begin
            r_buf  <= i_data;
            r_idx  <= '0;
            r_full <= 1'b1;
        end else if (o_consume) begin
            if (w_last) begin
                r_idx  <= '0;
                r_full <= 1'b0;
            end else begin
                r_idx  <= r_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises a word stream onto the head of the ccff chain, then optionally
// recirculates the chain once to compare a CRC of the read-back bits with
// the CRC of the loaded bits.
// Ports:
//   i_prog_clk, i_prog_rst_n : configuration clock, async active-low reset
//   i_start, i_verify_en     : begin a load (IDLE/DONE only), request verify
//   i_in_data/i_in_valid     : word stream, o_in_ready its handshake
//   o_ccff_head, o_ccff_shift_en, i_ccff_tail : chain interface
//   o_busy, o_done, o_pass   : status; o_pass valid while o_done=1
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              i_prog_clk,
    input  logic              i_prog_rst_n,
    input  logic              i_start,
    input  logic              i_verify_en,
    input  logic [WORD_W-1:0] i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_ccff_head,
    output logic              o_ccff_shift_en,
    input  logic              i_ccff_tail,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass
);

    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    state_t           r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [15:0]      r_crc_ld;
    logic [15:0]      r_crc_rb;
    logic             r_verify;
    logic             r_head;
    logic             r_shift_en;
    logic             r_pass;
    logic             w_start_ok;
    logic             w_at_end;
    logic             w_ser_clear;
    logic             w_ser_enable;
    logic             w_bit;
    logic             w_bit_valid;
    logic             w_consume;
    logic [15:0]      w_crc_ld_next;
    logic [15:0]      w_crc_rb_next;

    // Reset synchroniser: assertion is immediate, release waits two edges.
    always_ff @(posedge i_prog_clk or negedge i_prog_rst_n) begin
        if (!i_prog_rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_start_ok    = i_start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_at_end      = (r_state == ST_LOAD) & (r_bit_cnt == CNT_END);
    assign w_ser_clear   = w_start_ok | w_at_end;
    assign w_ser_enable  = (r_state == ST_LOAD) & ~w_at_end;
    assign w_crc_ld_next = crc16_step(r_crc_ld, w_bit);
    assign w_crc_rb_next = crc16_step(r_crc_rb, i_ccff_tail);

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .i_clk       (i_prog_clk),
        .i_rst_n     (w_rst_n),
        .i_clear     (w_ser_clear),
        .i_enable    (w_ser_enable),
        .i_data      (i_in_data),
        .i_valid     (i_in_valid),
        .o_ready     (o_in_ready),
        .o_bit       (w_bit),
        .o_bit_valid (w_bit_valid),
        .o_consume   (w_consume)
    );

    // Loader FSM, bit counter, CRCs and registered chain outputs.
    always_ff @(posedge i_prog_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_crc_ld   <= 16'h0000;
            r_crc_rb   <= 16'h0000;
            r_verify   <= 1'b0;
            r_head     <= 1'b0;
            r_shift_en <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_shift_en <= 1'b0;
                    if (w_start_ok) begin
                        r_state   <= ST_LOAD;
                        r_bit_cnt <= '0;
                        r_crc_ld  <= CRC16_INIT;
                        r_crc_rb  <= CRC16_INIT;
                        r_verify  <= i_verify_en;
                        r_pass    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_consume && w_bit_valid) begin
                        // Bit goes out on the head next cycle; count it now.
                        r_head     <= w_bit;
                        r_shift_en <= 1'b1;
                        r_crc_ld   <= w_crc_ld_next;
                        r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                    end else if (w_at_end) begin
                        // Last loaded bit is shifting now; verify follows with
                        // no gap so the enable stays high across the boundary.
                        r_bit_cnt  <= '0;
                        r_shift_en <= r_verify;
                        r_pass     <= ~r_verify;
                        r_state    <= r_verify ? ST_VERIFY : ST_DONE;
                    end else begin
                        r_shift_en <= 1'b0;
                    end
                end
                ST_VERIFY: begin
                    r_crc_rb <= w_crc_rb_next;
                    if (r_bit_cnt == CNT_LAST) begin
                        r_shift_en <= 1'b0;
                        r_pass     <= (w_crc_rb_next == r_crc_ld);
                        r_state    <= ST_DONE;
                    end else begin
                        r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_shift_en <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Loopback is only closed while recirculating.
    assign o_ccff_head     = (r_state == ST_VERIFY) ? i_ccff_tail : r_head;
    assign o_ccff_shift_en = r_shift_en;
    assign o_busy          = (r_state == ST_LOAD) | (r_state == ST_VERIFY);
    assign o_done          = (r_state == ST_DONE);
    assign o_pass          = r_pass;

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Upstream driver of the configuration flip-flop chain: takes bitstream words over a valid/ready stream and serialises them onto the chain head, one bit per prog_clk.
- Optional verify pass: recirculates the chain (tail fed back to head) for exactly CHAIN_LEN shifts. This restores the original contents and lets the block compare a CRC-16 of the bits read back against the CRC of the bits loaded.
- Sits between the fabric's configuration port and the head of the ccff chain.

Parameters:
- WORD_W, 8, input word width in bits; bits are serialised LSB first.
- CHAIN_LEN, 1024, number of flip-flops in the chain; range 2..65535.
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter (derived; do not override).

Ports:
- prog_clk  input  1  configuration clock; everything is sampled on the rising edge.
- prog_rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load. Honoured only in IDLE or DONE.
- verify_en  input  1  sampled with start; 1 means run the VERIFY pass after LOAD.
- in_data  input  WORD_W  bitstream word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  the loader accepts in_data this cycle.
- ccff_head  output  1  serial bit into the chain.
- ccff_shift_en  output  1  the chain shifts at the edge that ends this cycle (drives the chain clock-gate enable).
- ccff_tail  input  1  serial bit leaving the chain.
- busy  output  1  state is LOAD or VERIFY.
- done  output  1  state is DONE.
- pass  output  1  valid when done=1: CRCs matched, or verify was skipped.

Behaviour:
- Reset (async assert, sync deassert internally):
  - state=IDLE; all outputs 0.
  - Counters, word buffer and CRCs cleared.
  - Chain contents after reset mid-operation are undefined; software must reload.
- States are IDLE, LOAD, VERIFY, DONE.
- start:
  - In IDLE or DONE, start=1 moves to LOAD: bit_cnt=0, crc_ld=16'hFFFF, crc_rb=16'hFFFF, buffer emptied, verify_en latched.
  - start in LOAD or VERIFY is ignored.
- Word buffer:
  - One WORD_W shift register plus a bit index.
  - in_ready=1 in LOAD when the buffer is empty, or when the current bit is the word's last bit (bit index = WORD_W-1). This allows back-to-back words with no bubble.
  - A word is accepted on an edge where in_valid and in_ready are both 1.
- LOAD:
  - ccff_head and ccff_shift_en are registered outputs.
  - In each cycle with a buffered bit: ccff_shift_en=1 and ccff_head = current bit. At that edge, crc_ld updates with the bit and bit_cnt increments.
  - Buffer empty: ccff_shift_en=0 (stall), and ccff_head holds its last value.
- End of LOAD:
  - Once CHAIN_LEN bits have been shifted, the remaining bits of the current word are discarded and the buffer is cleared. in_ready is 0 on that cycle and afterwards.
  - Next state is VERIFY if verify_en was latched, otherwise DONE with pass=1.
- VERIFY:
  - ccff_shift_en=1 for exactly CHAIN_LEN consecutive cycles, with ccff_head = ccff_tail (combinational loopback, allowed only in this state).
  - crc_rb updates with ccff_tail each cycle.
  - Then DONE, with pass = (crc_rb == crc_ld).
  - The chain contents are unchanged after VERIFY.
- CRC:
  - CRC-16/CCITT, polynomial 0x1021, init 0xFFFF, one bit per update, MSB-first register.
  - feedback = crc[15]^bit; crc = {crc[14:0],1'b0} ^ (feedback ? 16'h1021 : 0).
- DONE:
  - done=1 and pass hold until the next start.
  - No shifting; in_ready=0.
- Outputs outside LOAD/VERIFY: ccff_shift_en=0 and in_ready=0.
- bit_cnt never wraps. The terminal compare is == CHAIN_LEN.

Decomposition:
- Shared package ccff_loader_pkg holds:
  - state enum {IDLE, LOAD, VERIFY, DONE};
  - CRC16_POLY=16'h1021 and CRC16_INIT=16'hFFFF;
  - function crc16_step(crc, bit).
- One sub-module, ccff_word_serializer: the word buffer, in_ready generation and bit index. It exports bit, bit_valid and consume.

Test Plan:
- CHAIN_LEN=20, WORD_W=8, verify_en=0, words 8'hA5, 8'h3C, 8'hFF sent back to back:
  - ccff_shift_en high for exactly 20 consecutive cycles;
  - head sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1;
  - last 4 bits of 8'hFF discarded; done=1, pass=1.
- Same stream with in_valid low for 3 cycles between words: ccff_shift_en low for exactly those 3 cycles; total shifts still 20.
- verify_en=1, chain model is an ideal 20-bit shift register:
  - LOAD then VERIFY of 20 cycles; pass=1;
  - model contents identical before and after VERIFY.
- verify_en=1 with the model flipping one tail bit during VERIFY: done=1, pass=0.
- prog_rst_n asserted after 10 LOAD shifts:
  - busy, ccff_shift_en and in_ready go 0 immediately (asynchronously);
  - after release, start reloads all 20 bits correctly.
- start pulsed mid-LOAD and mid-VERIFY: ignored, shift counts unchanged. start in DONE: new load begins and done drops the next cycle.
